pipe_hazard_ctrl: RTL and testbench

- Sequences the 5-stage pipelined datapath: detects load-use hazards, branch-taken flushes and data-memory wait states.
- Drives the PC/IF-ID write enables, bubble/flush controls and the EX-stage forwarding selects.
- Keeps its own shadow copy of destination register and MemRead/RegWrite for the ID/EX, EX/MEM and MEM/WB stages, so the datapath registers need no extra taps.
- Sits between the Control decoder output (ID stage) and the pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/fwd_select.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller and the Control decoder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN        = 2'd0;
    localparam state_t ST_LOAD_STALL = 2'd1;
    localparam state_t ST_BR_FLUSH   = 2'd2;
    localparam state_t ST_MEM_WAIT   = 2'd3;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] MR_NONE = 2'b00;
    localparam logic [1:0] MR_W    = 2'b01;
    localparam logic [1:0] MR_B    = 2'b10;
    localparam logic [1:0] MR_H    = 2'b11;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding priority compare: EX/MEM beats MEM/WB beats regfile.
// Latency: combinational.
// Backpressure: none; pure function of the shadow stage contents.
module fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src,
    input  logic [RA_W-1:0] exmem_dest,
    input  logic            exmem_fwd,
    input  logic [RA_W-1:0] memwb_dest,
    input  logic            memwb_fwd,
    output logic [1:0]      sel
);

    always_comb begin
        sel = FWD_RF;
        if (src != '0) begin
            if (exmem_fwd && (exmem_dest == src)) begin
                sel = FWD_MEM;
            end else if (memwb_fwd && (memwb_dest == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: load-use stall, taken-branch flush, dmem wait, forwarding selects.
// Latency: stall/flush/forward outputs are combinational; MEM_WAIT hold starts the cycle after the miss.
// Backpressure: mem_ready low freezes EX/MEM and upstream; FWD_UNIT_EN off turns every RAW into a stall.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W      = 5,
    parameter int FLUSH_CYC = 1,
    parameter int MEM_TMO   = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_uses_rt,
    input  logic [RA_W-1:0] id_dest,
    input  logic            id_regwrite,
    input  logic [1:0]      id_memread,
    input  logic            ex_branch_taken,
    input  logic            mem_req,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            ifid_flush,
    output logic            idex_bubble,
    output logic            exmem_hold,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            mem_timeout
);

    localparam logic [3:0] TMO_LAST   = 4'(MEM_TMO - 1);
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYC);

    state_t          state;
    logic [1:0]      br_cnt;
    logic [3:0]      wait_cnt;
    logic            br_pend;
    logic            timeout_q;

    logic [RA_W-1:0] idex_dest;
    logic            idex_rw;
    logic [1:0]      idex_mr;
    logic [RA_W-1:0] exmem_dest;
    logic            exmem_rw;
    logic [1:0]      exmem_mr;

    logic            in_wait;
    logic            mem_stall;
    logic            br_evt;
    logic            stall_evt;
    logic            idex_hit;
    logic            raw_hit;

    assign in_wait   = (state == ST_MEM_WAIT);
    assign mem_stall = mem_req && !mem_ready;

    assign idex_hit = (idex_dest != '0) &&
                      ((idex_dest == id_rs) || (id_uses_rt && (idex_dest == id_rt)));

`ifdef FWD_UNIT_EN
    logic [RA_W-1:0] idex_rs;
    logic [RA_W-1:0] idex_rt;
    logic [RA_W-1:0] memwb_dest;
    logic            memwb_rw;

    // Only a load in EX cannot be forwarded in time.
    assign raw_hit = (idex_mr != MR_NONE) && idex_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_rs    <= '0;
            idex_rt    <= '0;
            memwb_dest <= '0;
            memwb_rw   <= 1'b0;
        end else if (!exmem_hold) begin
            idex_rs    <= idex_bubble ? '0 : id_rs;
            idex_rt    <= (idex_bubble || !id_uses_rt) ? '0 : id_rt;
            memwb_dest <= exmem_dest;
            memwb_rw   <= exmem_rw;
        end
    end

    // Load data is not available out of EX/MEM, so only ALU results forward from there.
    fwd_select #(.RA_W(RA_W)) u_fwd_a (
        .src        (idex_rs),
        .exmem_dest (exmem_dest),
        .exmem_fwd  (exmem_rw && (exmem_mr == MR_NONE)),
        .memwb_dest (memwb_dest),
        .memwb_fwd  (memwb_rw),
        .sel        (fwd_a)
    );

    fwd_select #(.RA_W(RA_W)) u_fwd_b (
        .src        (idex_rt),
        .exmem_dest (exmem_dest),
        .exmem_fwd  (exmem_rw && (exmem_mr == MR_NONE)),
        .memwb_dest (memwb_dest),
        .memwb_fwd  (memwb_rw),
        .sel        (fwd_b)
    );
`else
    logic exmem_hit;

    assign exmem_hit = (exmem_dest != '0) &&
                       ((exmem_dest == id_rs) || (id_uses_rt && (exmem_dest == id_rt)));

    // No bypass: wait until the producer has left EX/MEM.
    assign raw_hit = ((idex_rw || (idex_mr != MR_NONE)) && idex_hit) ||
                     ((exmem_rw || (exmem_mr != MR_NONE)) && exmem_hit);

    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    // A branch arriving while memory stalls is deferred via br_pend.
    assign br_evt    = (ex_branch_taken || br_pend) && !in_wait && !mem_stall;
    assign stall_evt = raw_hit && !in_wait && !br_evt && (state != ST_BR_FLUSH);

    assign pc_write    = !in_wait && !stall_evt;
    assign ifid_write  = !in_wait && !stall_evt;
    assign ifid_flush  = br_evt || (state == ST_BR_FLUSH);
    assign idex_bubble = br_evt || stall_evt;
    assign exmem_hold  = in_wait;
    assign mem_timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            br_cnt    <= '0;
            wait_cnt  <= '0;
            br_pend   <= 1'b0;
            timeout_q <= 1'b0;
        end else if (in_wait) begin
            if (ex_branch_taken) begin
                br_pend <= 1'b1;
            end
            if (mem_ready) begin
                state <= ST_RUN;
            end else if (wait_cnt == TMO_LAST) begin
                timeout_q <= 1'b1;
                state     <= ST_RUN;
            end else begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end else if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
            if (ex_branch_taken) begin
                br_pend <= 1'b1;
            end
        end else if (br_evt) begin
            state   <= ST_BR_FLUSH;
            br_cnt  <= FLUSH_INIT;
            br_pend <= 1'b0;
        end else if (state == ST_BR_FLUSH) begin
            if (br_cnt <= 2'd1) begin
                state <= ST_RUN;
            end else begin
                br_cnt <= br_cnt - 2'd1;
            end
        end else begin
            state <= stall_evt ? ST_LOAD_STALL : ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_dest  <= '0;
            idex_rw    <= 1'b0;
            idex_mr    <= MR_NONE;
            exmem_dest <= '0;
            exmem_rw   <= 1'b0;
            exmem_mr   <= MR_NONE;
        end else if (!exmem_hold) begin
            idex_dest  <= idex_bubble ? '0 : id_dest;
            idex_rw    <= !idex_bubble && id_regwrite;
            idex_mr    <= idex_bubble ? MR_NONE : id_memread;
            exmem_dest <= idex_dest;
            exmem_rw   <= idex_rw;
            exmem_mr   <= idex_mr;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations adapt to the FWD_UNIT_EN build.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [4:0] dest;
        logic       rw;
        logic [1:0] mr;
    } instr_t;

    // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}
    localparam logic [7:0] C_RUN   = 8'h18;
    localparam logic [7:0] C_STALL = 8'h02;
    localparam logic [7:0] C_BR    = 8'h1E;
    localparam logic [7:0] C_FLUSH = 8'h1C;
    localparam logic [7:0] C_HOLD  = 8'h01;

    localparam instr_t NOP    = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00};
    localparam instr_t LW2    = '{5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 2'b01};
    localparam instr_t ADD324 = '{5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 2'b00};
    localparam instr_t ADD511 = '{5'd1, 5'd1, 1'b1, 5'd5, 1'b1, 2'b00};
    localparam instr_t SUB655 = '{5'd5, 5'd5, 1'b1, 5'd6, 1'b1, 2'b00};
    localparam instr_t LW0    = '{5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 2'b01};
    localparam instr_t ADD000 = '{5'd0, 5'd0, 1'b1, 5'd7, 1'b1, 2'b00};

`ifdef FWD_UNIT_EN
    localparam int         LU_STALLS  = 1;
    localparam int         ALU_STALLS = 0;
    localparam logic [7:0] LU_FWD     = 8'h04;
    localparam logic [7:0] ALU_FWD    = 8'h0A;
`else
    localparam int         LU_STALLS  = 2;
    localparam int         ALU_STALLS = 2;
    localparam logic [7:0] LU_FWD     = 8'h00;
    localparam logic [7:0] ALU_FWD    = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       id_uses_rt, id_regwrite;
    logic [1:0] id_memread;
    logic       ex_branch_taken, mem_req, mem_ready;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, mem_timeout;
    logic [1:0] fwd_a, fwd_b;

    int vec_cnt     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RA_W(5), .FLUSH_CYC(1), .MEM_TMO(15)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_dest         (id_dest),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .exmem_hold      (exmem_hold),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .mem_timeout     (mem_timeout)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic drive(input instr_t i);
        id_rs       = i.rs;
        id_rt       = i.rt;
        id_uses_rt  = i.uses_rt;
        id_dest     = i.dest;
        id_regwrite = i.rw;
        id_memread  = i.mr;
    endtask

    task automatic sample(input string tag, input logic [7:0] exp_ctl);
        @(negedge clk);
        chk(tag, {3'b000, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}, exp_ctl);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(NOP);
        ex_branch_taken = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
        adv();
        adv();
        rst = 1'b0;
    endtask

    task automatic run_pair(input string tag, input instr_t p, input instr_t c,
                            input int nstall, input logic [7:0] exp_fwd);
        do_reset();
        drive(p);
        sample({tag, " producer"}, C_RUN);
        adv();
        drive(c);
        for (int i = 0; i < nstall; i++) begin
            sample({tag, " stall"}, C_STALL);
            adv();
        end
        sample({tag, " issue"}, C_RUN);
        adv();
        drive(NOP);
        sample({tag, " ex cycle"}, C_RUN);
        chk({tag, " fwd"}, {4'b0000, fwd_a, fwd_b}, exp_fwd);
        adv();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(NOP);
        ex_branch_taken = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
        adv();
        sample("reset ctl", C_RUN);
        chk("reset fwd", {4'b0000, fwd_a, fwd_b}, 8'h00);
        chk("reset timeout", {7'd0, mem_timeout}, 8'h00);

        run_pair("load-use", LW2, ADD324, LU_STALLS, LU_FWD);
        run_pair("alu-raw", ADD511, SUB655, ALU_STALLS, ALU_FWD);
        run_pair("dest0 load", LW0, ADD000, 0, 8'h00);

        do_reset();
        ex_branch_taken = 1'b1;
        sample("branch detect", C_BR);
        adv();
        ex_branch_taken = 1'b0;
        sample("branch flush", C_FLUSH);
        adv();
        sample("branch done", C_RUN);
        adv();

        do_reset();
        drive(LW2);
        sample("br+lu producer", C_RUN);
        adv();
        drive(ADD324);
        ex_branch_taken = 1'b1;
        sample("br+lu detect", C_BR);
        adv();
        ex_branch_taken = 1'b0;
        drive(NOP);
        sample("br+lu flush", C_FLUSH);
        adv();
        sample("br+lu done", C_RUN);
        adv();

        do_reset();
        mem_req = 1'b1;
        sample("memwait miss", C_RUN);
        adv();
        for (int i = 0; i < 2; i++) begin
            sample("memwait hold", C_HOLD);
            adv();
        end
        mem_ready = 1'b1;
        sample("memwait ready", C_HOLD);
        adv();
        mem_req   = 1'b0;
        mem_ready = 1'b0;
        sample("memwait release", C_RUN);
        chk("memwait no timeout", {7'd0, mem_timeout}, 8'h00);
        adv();

        do_reset();
        mem_req = 1'b1;
        sample("tmo miss", C_RUN);
        adv();
        for (int i = 1; i <= 15; i++) begin
            sample("tmo hold", C_HOLD);
            if (i == 15) chk("tmo not yet", {7'd0, mem_timeout}, 8'h00);
            adv();
        end
        mem_req = 1'b0;
        sample("tmo exit", C_RUN);
        chk("tmo set", {7'd0, mem_timeout}, 8'h01);
        adv();
        adv();
        adv();
        sample("tmo idle", C_RUN);
        chk("tmo sticky", {7'd0, mem_timeout}, 8'h01);
        do_reset();
        sample("tmo after rst", C_RUN);
        chk("tmo cleared", {7'd0, mem_timeout}, 8'h00);

        do_reset();
        mem_req = 1'b1;
        sample("br-in-wait miss", C_RUN);
        adv();
        ex_branch_taken = 1'b1;
        sample("br-in-wait hold", C_HOLD);
        adv();
        mem_ready = 1'b1;
        sample("br-in-wait ready", C_HOLD);
        adv();
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
        ex_branch_taken = 1'b0;
        sample("br-in-wait deferred", C_BR);
        adv();
        sample("br-in-wait flush", C_FLUSH);
        adv();
        sample("br-in-wait done", C_RUN);
        adv();

        do_reset();
        ex_branch_taken = 1'b1;
        sample("rst-flush detect", C_BR);
        adv();
        ex_branch_taken = 1'b0;
        rst = 1'b1;
        sample("rst-flush pending", C_FLUSH);
        adv();
        rst = 1'b0;
        sample("rst-flush cleared", C_RUN);
        adv();

        do_reset();
        mem_req = 1'b1;
        sample("rst-wait miss", C_RUN);
        adv();
        mem_req = 1'b0;
        rst = 1'b1;
        sample("rst-wait hold", C_HOLD);
        adv();
        rst = 1'b0;
        sample("rst-wait cleared", C_RUN);
        adv();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
